// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, external and DRAM-side signals of the data-RAM arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requests.
interface dmem_port_arbiter_if #(
    parameter int DRAM_AW = 14
);
    logic               cpu_req_i;
    logic               cpu_we_i;
    logic [31:0]        cpu_addr_i;
    logic [31:0]        cpu_wdata_i;
    logic [3:0]         cpu_be_i;
    logic               cpu_stall_o;
    logic               cpu_rvalid_o;
    logic [31:0]        cpu_rdata_o;

    logic               ext_req_i;
    logic               ext_we_i;
    logic [31:0]        ext_addr_i;
    logic [31:0]        ext_wdata_i;
    logic [3:0]         ext_be_i;
    logic               ext_gnt_o;
    logic               ext_rvalid_o;
    logic [31:0]        ext_rdata_o;
    logic               ext_halt_req_i;
    logic               ext_halted_o;

    logic               dram_en_o;
    logic [3:0]         dram_we_o;
    logic [DRAM_AW-1:0] dram_addr_o;
    logic [31:0]        dram_wdata_o;
    logic [31:0]        dram_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
        output cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
        input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i, ext_halt_req_i,
        output ext_gnt_o, ext_rvalid_o, ext_rdata_o, ext_halted_o,
        output dram_en_o, dram_we_o, dram_addr_o, dram_wdata_o,
        input  dram_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
        input  cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
        output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i, ext_halt_req_i,
        input  ext_gnt_o, ext_rvalid_o, ext_rdata_o, ext_halted_o,
        input  dram_en_o, dram_we_o, dram_addr_o, dram_wdata_o,
        output dram_rdata_i
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the MEM stage and an external
// debug/loader port, with starvation relief and a drain-then-halt handshake.
module dmem_port_arbiter #(
    parameter int DRAM_AW    = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_own_q, rd_own_d;
    logic        ext_halted_q, ext_halted_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic        cpu_gnt;
    logic        ext_gnt;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // Outside RUN the CPU is locked out and the external side owns the RAM.
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (state_q == RUN) begin
            ext_gnt = bus.ext_req_i & (~bus.cpu_req_i | (wait_cnt_q == STARVE_LIM));
            cpu_gnt = bus.cpu_req_i & ~ext_gnt;
        end else begin
            ext_gnt = bus.ext_req_i;
        end
    end

    always_comb begin
        sel_addr         = 32'd0;
        bus.dram_we_o    = 4'd0;
        bus.dram_wdata_o = 32'd0;
        if (ext_gnt) begin
            sel_addr         = bus.ext_addr_i;
            bus.dram_we_o    = bus.ext_we_i ? bus.ext_be_i : 4'd0;
            bus.dram_wdata_o = bus.ext_wdata_i;
        end else if (cpu_gnt) begin
            sel_addr         = bus.cpu_addr_i;
            bus.dram_we_o    = bus.cpu_we_i ? bus.cpu_be_i : 4'd0;
            bus.dram_wdata_o = bus.cpu_wdata_i;
        end
    end

    assign bus.dram_addr_o  = sel_addr[DRAM_AW+1:2];
    assign unused_addr_bits = ^{sel_addr[31:DRAM_AW+2], sel_addr[1:0]};
    assign bus.dram_en_o    = cpu_gnt | ext_gnt;
    assign bus.cpu_stall_o  = bus.cpu_req_i & ~cpu_gnt;
    assign bus.ext_gnt_o    = ext_gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.ext_halt_req_i) state_d = DRAIN;
            DRAIN:   if (!bus.ext_halt_req_i) state_d = RUN;
                     else if (!rd_pend_q)     state_d = HALT;
            HALT:    if (!bus.ext_halt_req_i) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (!bus.ext_req_i || ext_gnt)
            wait_cnt_d = 4'd0;
        else if (cpu_gnt && (wait_cnt_q < STARVE_LIM))
            wait_cnt_d = wait_cnt_q + 4'd1;
        else
            wait_cnt_d = wait_cnt_q;

        rd_pend_d    = (cpu_gnt & ~bus.cpu_we_i) | (ext_gnt & ~bus.ext_we_i);
        rd_own_d     = ext_gnt;
        ext_halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            rd_pend_q    <= 1'b0;
            rd_own_q     <= 1'b0;
            ext_halted_q <= 1'b0;
            wait_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            rd_own_q     <= rd_own_d;
            ext_halted_q <= ext_halted_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Read data lands one cycle after issue; steer it only to the owner.
    assign bus.cpu_rvalid_o = rd_pend_q & ~rd_own_q;
    assign bus.ext_rvalid_o = rd_pend_q & rd_own_q;
    assign bus.cpu_rdata_o  = bus.cpu_rvalid_o ? bus.dram_rdata_i : 32'd0;
    assign bus.ext_rdata_o  = bus.ext_rvalid_o ? bus.dram_rdata_i : 32'd0;
    assign bus.ext_halted_o = ext_halted_q;
endmodule
